// File: rtl/sobel_window_addr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sobel_pkg                                                    |
// | Description : Shared types for the Sobel window address generator:        |
// |               controller state encoding, move-direction encoding and the   |
// |               largest supported kernel size.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package sobel_pkg;

  // Largest supported (odd) kernel size; also sizes the fetch counters
  localparam int K_MAX = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Encoding is visible on the dir output port
  typedef enum logic [1:0] {
    DIR_IDLE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

endpackage
`default_nettype wire

// File: rtl/sobel_window_coord.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sobel_window_coord                                           |
// | Description : Tracks the top-left corner (wx,wy) of the current window,    |
// |               the serpentine horizontal direction, and decides the next    |
// |               move (right / left / down) or that the frame is complete.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sobel_window_coord
  import sobel_pkg::*;
#(
  parameter int DIM_W = 12,
  parameter int K     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_step,
  input  logic [DIM_W-1:0] i_cols,
  input  logic [DIM_W-1:0] i_rows,
  output dir_t             o_move,
  output logic             o_last
);

  logic [DIM_W-1:0] r_wx;
  logic [DIM_W-1:0] r_wy;
  logic             r_go_left;
  logic [DIM_W-1:0] w_x_max;
  logic [DIM_W-1:0] w_y_max;

  // Largest legal top-left coordinate in each axis
  assign w_x_max = i_cols - DIM_W'(K);
  assign w_y_max = i_rows - DIM_W'(K);

  // Next move: continue along the row, else drop a row, else the frame is done
  always_comb begin
    o_move = DIR_IDLE;
    o_last = 1'b0;
    if (!r_go_left && (r_wx < w_x_max)) begin
      o_move = DIR_RIGHT;
    end else if (r_go_left && (r_wx != '0)) begin
      o_move = DIR_LEFT;
    end else if (r_wy < w_y_max) begin
      o_move = DIR_DOWN;
    end else begin
      o_last = 1'b1;
    end
  end

  // Apply the chosen move; a down move reverses the horizontal sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wx      <= '0;
      r_wy      <= '0;
      r_go_left <= 1'b0;
    end else if (i_init) begin
      r_wx      <= '0;
      r_wy      <= '0;
      r_go_left <= 1'b0;
    end else if (i_step) begin
      case (o_move)
        DIR_RIGHT: r_wx <= r_wx + DIM_W'(1);
        DIR_LEFT:  r_wx <= r_wx - DIM_W'(1);
        DIR_DOWN: begin
          r_wy      <= r_wy + DIM_W'(1);
          r_go_left <= ~r_go_left;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_window_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sobel_window_addr                                            |
// | Description : Generates read addresses for a KxK sliding window scanned    |
// |               in serpentine order (full fetch for the first window, one    |
// |               new column/row per move) and one centre write address per    |
// |               window. Addresses are built by accumulation, no multiplier.  |
// |               Optional: define SOBEL_WINDOW_ADDR_PERF_EN to add the        |
// |               saturating win_count output.                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sobel_window_addr
  import sobel_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 12,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_cols,
  input  logic [DIM_W-1:0]  img_rows,
  input  logic [ADDR_W-1:0] base_addr_r,
  input  logic [ADDR_W-1:0] base_addr_w,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        dir,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef SOBEL_WINDOW_ADDR_PERF_EN
  ,
  output logic [31:0]       win_count
`endif
);

  localparam int CW = $clog2(K_MAX);
  localparam int C  = (K - 1) / 2;
  localparam logic [CW-1:0] c_KM1 = CW'(K - 1);
  localparam logic [CW-1:0] c_KM2 = CW'(K - 2);
  localparam logic [CW-1:0] c_CTR = CW'(C);

  state_t            r_state;
  logic [DIM_W-1:0]  r_cols;
  logic [DIM_W-1:0]  r_rows;
  logic [ADDR_W-1:0] r_win;      // read address of window top-left pixel
  logic [ADDR_W-1:0] r_bot;      // read address of window bottom-left pixel
  logic [ADDR_W-1:0] r_line;     // start of current row during the full fetch
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [ADDR_W-1:0] r_wr_addr;  // write address of current window centre
  logic              r_wr_valid;
  dir_t              r_dir;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;
  logic [CW-1:0]     r_cnt_in;
  logic [CW-1:0]     r_cnt_out;

  logic [ADDR_W-1:0] w_cols_a;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_cfg_bad;
  logic              w_init;
  logic              w_step;
  dir_t              w_move;
  logic              w_last;

  assign w_cols_a  = ADDR_W'(r_cols);
  assign w_rd_fire = r_rd_valid && rd_ready;
  assign w_wr_fire = r_wr_valid && wr_ready;
  assign w_cfg_bad = (img_cols < DIM_W'(K)) || (img_rows < DIM_W'(K));
  assign w_init    = (r_state == ST_IDLE) && start && !w_cfg_bad;
  assign w_step    = (r_state == ST_WRITE) && w_wr_fire && !w_last;

  sobel_window_coord #(
    .DIM_W (DIM_W),
    .K     (K)
  ) u_coord (
    .clk    (clk),
    .rst    (reset),
    .i_init (w_init),
    .i_step (w_step),
    .i_cols (r_cols),
    .i_rows (r_rows),
    .o_move (w_move),
    .o_last (w_last)
  );

  // Frame controller: fetch sequencing, write issue and incremental addressing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cols     <= '0;
      r_rows     <= '0;
      r_win      <= '0;
      r_bot      <= '0;
      r_line     <= '0;
      r_rd_addr  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_valid <= 1'b0;
      r_dir      <= DIR_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_cnt_in   <= '0;
      r_cnt_out  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_cfg_err  <= 1'b0;
              r_busy     <= 1'b1;
              r_cols     <= img_cols;
              r_rows     <= img_rows;
              r_win      <= base_addr_r;
              r_line     <= base_addr_r;
              r_rd_addr  <= base_addr_r;
              // column offset of the centre now; row offset accrues during the fill
              r_wr_addr  <= base_addr_w + ADDR_W'(C);
              r_cnt_in   <= '0;
              r_cnt_out  <= '0;
              r_rd_valid <= 1'b1;
              r_rd_last  <= 1'b0;
              r_dir      <= DIR_RIGHT;
              r_state    <= ST_FILL;
            end
          end
        end

        ST_FILL: begin
          if (w_rd_fire) begin
            if (r_cnt_in == c_KM1) begin
              if (r_cnt_out == c_KM1) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
                r_bot      <= r_line;
                r_wr_valid <= 1'b1;
                r_state    <= ST_WRITE;
              end else begin
                r_cnt_in  <= '0;
                r_cnt_out <= r_cnt_out + CW'(1);
                r_line    <= r_line + w_cols_a;
                r_rd_addr <= r_line + w_cols_a;
                if (r_cnt_out < c_CTR) begin
                  r_wr_addr <= r_wr_addr + w_cols_a;
                end
              end
            end else begin
              r_cnt_in  <= r_cnt_in + CW'(1);
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
              r_rd_last <= (r_cnt_out == c_KM1) && (r_cnt_in == c_KM2);
            end
          end
        end

        ST_SHIFT: begin
          if (w_rd_fire) begin
            if (r_cnt_in == c_KM1) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_wr_valid <= 1'b1;
              r_state    <= ST_WRITE;
            end else begin
              r_cnt_in  <= r_cnt_in + CW'(1);
              r_rd_last <= (r_cnt_in == c_KM2);
              // down moves read a row; horizontal moves read a column
              if (r_dir == DIR_DOWN) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
              end else begin
                r_rd_addr <= r_rd_addr + w_cols_a;
              end
            end
          end
        end

        ST_WRITE: begin
          if (w_wr_fire) begin
            r_wr_valid <= 1'b0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_dir   <= DIR_IDLE;
              r_state <= ST_DONE;
            end else begin
              r_dir      <= w_move;
              r_cnt_in   <= '0;
              r_rd_valid <= 1'b1;
              r_rd_last  <= 1'b0;
              r_state    <= ST_SHIFT;
              case (w_move)
                DIR_RIGHT: begin
                  r_win     <= r_win + ADDR_W'(1);
                  r_bot     <= r_bot + ADDR_W'(1);
                  r_wr_addr <= r_wr_addr + ADDR_W'(1);
                  r_rd_addr <= r_win + ADDR_W'(K);
                end
                DIR_LEFT: begin
                  r_win     <= r_win - ADDR_W'(1);
                  r_bot     <= r_bot - ADDR_W'(1);
                  r_wr_addr <= r_wr_addr - ADDR_W'(1);
                  r_rd_addr <= r_win - ADDR_W'(1);
                end
                default: begin
                  r_win     <= r_win + w_cols_a;
                  r_bot     <= r_bot + w_cols_a;
                  r_wr_addr <= r_wr_addr + w_cols_a;
                  r_rd_addr <= r_bot + w_cols_a;
                end
              endcase
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_addr  = r_rd_addr;
  assign rd_last  = r_rd_last;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign dir      = r_dir;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;

`ifdef SOBEL_WINDOW_ADDR_PERF_EN
  logic [31:0] r_win_count;

  // Saturating count of accepted writes in the current frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_count <= '0;
    end else if (w_init) begin
      r_win_count <= '0;
    end else if (w_wr_fire && (r_win_count != '1)) begin
      r_win_count <= r_win_count + 32'd1;
    end
  end

  assign win_count = r_win_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sobel_window_addr                                         |
// | Description : Self-checking bench for sobel_window_addr (ADDR_W=8, K=3).   |
// |               Expected read/write streams come from a window-list model.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sobel_window_addr;

  localparam int AW = 8;
  localparam int DW = 12;
  localparam int K  = 3;
  localparam int C  = (K - 1) / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] img_cols;
  logic [DW-1:0] img_rows;
  logic [AW-1:0] base_addr_r;
  logic [AW-1:0] base_addr_w;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [1:0]    dir;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef SOBEL_WINDOW_ADDR_PERF_EN
  logic [31:0]   win_count;
`endif

  sobel_window_addr #(.ADDR_W(AW), .DIM_W(DW), .K(K)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .img_cols    (img_cols),
    .img_rows    (img_rows),
    .base_addr_r (base_addr_r),
    .base_addr_w (base_addr_w),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rd_last     (rd_last),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .dir         (dir),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
`ifdef SOBEL_WINDOW_ADDR_PERF_EN
    ,
    .win_count   (win_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // expected streams
  int q_ra[$];
  int q_rl[$];
  int q_rd[$];
  int q_wa[$];

  int n_rd, n_wr, n_done;
  bit mon_en = 1'b0;
  int rdy_mode = 0;
  int stall_left = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pa(input int base, input int x, input int y, input int cols);
    return (base + y * cols + x) % (1 << AW);
  endfunction

  task automatic push_rd(input int a, input int last, input int d);
    q_ra.push_back(a);
    q_rl.push_back(last);
    q_rd.push_back(d);
  endtask

  // Reference: list all windows in serpentine order, then derive new pixels per move
  task automatic build_model(input int cols, input int rows, input int br, input int bw);
    int wxs[$];
    int wys[$];
    q_ra.delete(); q_rl.delete(); q_rd.delete(); q_wa.delete();
    if (cols < K || rows < K) return;
    for (int y = 0; y <= rows - K; y++)
      for (int i = 0; i <= cols - K; i++) begin
        wxs.push_back((y % 2 == 0) ? i : (cols - K - i));
        wys.push_back(y);
      end
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        push_rd(pa(br, c, r, cols), (r == K-1 && c == K-1) ? 1 : 0, 1);
    q_wa.push_back(pa(bw, wxs[0] + C, wys[0] + C, cols));
    for (int n = 1; n < wxs.size(); n++) begin
      for (int k = 0; k < K; k++) begin
        if (wys[n] > wys[n-1])      push_rd(pa(br, wxs[n] + k, wys[n] + K - 1, cols), (k == K-1) ? 1 : 0, 3);
        else if (wxs[n] > wxs[n-1]) push_rd(pa(br, wxs[n] + K - 1, wys[n] + k, cols), (k == K-1) ? 1 : 0, 1);
        else                        push_rd(pa(br, wxs[n], wys[n] + k, cols), (k == K-1) ? 1 : 0, 2);
      end
      q_wa.push_back(pa(bw, wxs[n] + C, wys[n] + C, cols));
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = five-cycle read stall after 4 reads
  initial begin
    rd_ready = 1'b1;
    wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin
          rd_ready = ($urandom_range(0, 3) != 0);
          wr_ready = ($urandom_range(0, 2) != 0);
        end
        2: begin
          wr_ready = 1'b1;
          if (n_rd == 4 && stall_left > 0) begin
            rd_ready = 1'b0;
            stall_left--;
          end else rd_ready = 1'b1;
        end
        default: begin
          rd_ready = 1'b1;
          wr_ready = 1'b1;
        end
      endcase
    end
  end

  // Monitor: transfers against the model, hold stability while stalled
  bit rd_stall, wr_stall;
  int h_ra, h_rl, h_wa;
  always @(negedge clk) begin
    if (!mon_en || reset) begin
      rd_stall = 1'b0;
      wr_stall = 1'b0;
    end else begin
      if (rd_stall) begin
        check("rd_hold_valid", rd_valid, 1);
        check("rd_hold_addr", rd_addr, h_ra);
        check("rd_hold_last", rd_last, h_rl);
      end
      if (wr_stall) begin
        check("wr_hold_valid", wr_valid, 1);
        check("wr_hold_addr", wr_addr, h_wa);
      end
      if (rd_valid && rd_ready) begin
        n_rd++;
        if (q_ra.size() == 0) check("rd_extra", q_ra.size(), 1);
        else begin
          check("rd_addr", rd_addr, q_ra.pop_front());
          check("rd_last", rd_last, q_rl.pop_front());
          check("rd_dir", dir, q_rd.pop_front());
        end
      end
      if (wr_valid && wr_ready) begin
        n_wr++;
        if (q_wa.size() == 0) check("wr_extra", q_wa.size(), 1);
        else check("wr_addr", wr_addr, q_wa.pop_front());
      end
      if (done) n_done++;
      rd_stall = rd_valid && !rd_ready;
      wr_stall = wr_valid && !wr_ready;
      h_ra = rd_addr;
      h_rl = rd_last;
      h_wa = wr_addr;
    end
  end

  task automatic pulse_start(input int cols, input int rows, input int br, input int bw);
    @(posedge clk); #1;
    n_rd = 0; n_wr = 0; n_done = 0; mon_en = 1'b1;
    img_cols = DW'(cols); img_rows = DW'(rows);
    base_addr_r = AW'(br); base_addr_w = AW'(bw);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int cols, input int rows, input int br, input int bw, input int mode);
    bit bad;
    int nwin;
    int i;
    bad  = (cols < K) || (rows < K);
    nwin = bad ? 0 : (cols - K + 1) * (rows - K + 1);
    build_model(cols, rows, br, bw);
    rdy_mode = mode;
    pulse_start(cols, rows, br, bw);
    @(negedge clk);
    if (bad) begin
      check("bad_cfg_err", cfg_err, 1);
      check("bad_done", done, 1);
      check("bad_no_read", rd_valid, 0);
      check("bad_busy", busy, 0);
    end else begin
      check("first_rd_valid", rd_valid, 1);
      check("first_rd_addr", rd_addr, br % (1 << AW));
      check("start_busy", busy, 1);
      check("start_cfg_err", cfg_err, 0);
      check("fill_dir", dir, 1);
    end
    i = 0;
    while (!done && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("done_busy_low", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_dir", dir, 0);
    #1;
    mon_en = 1'b0;
    check("done_count", n_done, 1);
    check("rd_count", n_rd, bad ? 0 : (K*K + K*(nwin - 1)));
    check("wr_count", n_wr, nwin);
    check("rd_left", q_ra.size(), 0);
    check("wr_left", q_wa.size(), 0);
`ifdef SOBEL_WINDOW_ADDR_PERF_EN
    if (!bad) check("win_count", win_count, nwin);
`endif
  endtask

  initial begin
    int cols, rows, i;
    reset = 1'b1; start = 1'b0;
    img_cols = '0; img_rows = '0; base_addr_r = '0; base_addr_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_dir", dir, 0);
    reset = 1'b0;

    run_frame(5, 5, 0, 100, 0);
    run_frame(3, 5, 0, 0, 0);
    stall_left = 5;
    run_frame(5, 5, 0, 100, 2);
    check("stall_used", stall_left, 0);
    run_frame(2, 5, 0, 0, 0);
    run_frame(4, 4, 254, 10, 0);
    run_frame(5, 3, 17, 200, 1);

    // reset while a shift fetch is in progress
    build_model(6, 6, 40, 90);
    rdy_mode = 1;
    pulse_start(6, 6, 40, 90);
    i = 0;
    while (n_rd < 10 && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("reach_shift", n_rd >= 10, 1);
    @(posedge clk); #1;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_rd_last", rd_last, 0);
    check("mid_rst_wr_valid", wr_valid, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_dir", dir, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(6, 6, 40, 90, 1);

    for (int n = 0; n < 8; n++) begin
      cols = $urandom_range(3, 7);
      rows = $urandom_range(3, 7);
      run_frame(cols, rows, $urandom_range(0, 255), $urandom_range(0, 255), 1);
    end
    run_frame($urandom_range(3, 7), $urandom_range(0, 2), 0, 0, 1);
    run_frame(4, 5, $urandom_range(0, 255), $urandom_range(0, 255), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_window_addr.md
SOBEL_WINDOW_ADDR -- requirements
Module: sobel_window_addr

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DIM_W, default 12, image dimension width; K, default 3, odd kernel size, 3..7.
REQ-002 Ports SHALL be, in order:
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-high.
  start  in  1  one-cycle request to begin a frame.
  img_cols  in  DIM_W  image columns.
  img_rows  in  DIM_W  image rows.
  base_addr_r  in  ADDR_W  source frame base address.
  base_addr_w  in  ADDR_W  destination frame base address.
  rd_valid  out  1  rd_addr valid.
  rd_ready  in  1  consumer accepts rd_addr.
  rd_addr  out  ADDR_W  pixel read address.
  rd_last  out  1  final read of the current window fetch.
  wr_valid  out  1  wr_addr valid.
  wr_ready  in  1  consumer accepts wr_addr.
  wr_addr  out  ADDR_W  result write address.
  dir  out  2  00 idle, 01 right, 10 left, 11 down.
  busy  out  1  frame in progress.
  done  out  1  one-cycle end-of-frame pulse.
  cfg_err  out  1  last start rejected for bad dimensions.

Function
REQ-003 Address of pixel (x,y) SHALL be base + y*img_cols + x, modulo 2^ADDR_W; computed by incremental row-offset accumulation, no multiplier.
REQ-004 FSM states SHALL be IDLE, FILL, SHIFT, WRITE, DONE.
REQ-005 In IDLE, start SHALL latch all config inputs and go to FILL the next cycle; start while busy SHALL be ignored.
REQ-006 If img_cols<K or img_rows<K at start, the block SHALL set cfg_err, issue no reads, and pulse done one cycle after start.
REQ-007 On a valid start, cfg_err SHALL be cleared.
REQ-008 FILL SHALL issue K*K reads of window (0,0), row-major; the first rd_valid SHALL occur the cycle after start.
REQ-009 A transfer SHALL occur only when valid&&ready; rd_addr, wr_addr and rd_last SHALL hold stable while valid && !ready.
REQ-010 After each fetch, WRITE SHALL issue one wr_addr at the window centre, (wx+c, wy+c) with c=(K-1)/2, relative to base_addr_w.
REQ-011 Windows SHALL be scanned in serpentine order:
  - Right while wx<img_cols-K.
  - At the row end, if wy<img_rows-K: move down, then reverse horizontal direction.
  - Left while wx>0.
REQ-012 SHIFT SHALL issue K reads:
  - Right: new column x=wx+K-1, top to bottom.
  - Left: new column x=wx, top to bottom.
  - Down: new row y=wy+K-1, left to right.
REQ-013 dir SHALL show the current move; it SHALL be 01 during FILL and 00 in IDLE.
REQ-014 After the write of the final window, the block SHALL enter DONE, pulse done for one cycle, and return to IDLE; busy SHALL deassert in the same cycle that done asserts.
REQ-015 When img_cols==K, the block SHALL make down moves only; when img_rows==K, horizontal moves only; when both equal K, exactly one window.
REQ-016 The block SHALL issue (C-K+1)*(R-K+1) writes per frame and K*K + K*(windows-1) reads per frame.

Reset
REQ-017 reset SHALL asynchronously force IDLE and clear all outputs, coordinates, counters and cfg_err to zero, including mid-frame; there SHALL be no resumption after reset.

Configuration
REQ-018 With SOBEL_WINDOW_ADDR_PERF_EN defined, the block SHALL add output win_count[31:0]:
  - incremented on each accepted write;
  - cleared on valid start and on reset;
  - saturating at all-ones.
  Without the macro, the port and its logic SHALL be absent.

Structure
REQ-019 Package sobel_pkg SHALL hold the state enum, the dir_t encoding (DIR_IDLE/RIGHT/LEFT/DOWN), and constant K_MAX=7.
REQ-020 Sub-module sobel_window_coord SHALL own wx/wy, serpentine direction and end-of-frame detection; the top level SHALL own the FSM, address arithmetic and handshakes.

Verification
REQ-021 Bench SHALL cover:
  - 5x5, K=3, bases 0/100, ready tied high: reads 0,1,2,5,6,7,10,11,12 then write 106; next reads 3,8,13, write 107; 33 reads and 9 writes total; done once.
  - 3x5 (cols=3, rows=5), K=3, bases 0/0: writes 4,7,10; dir=11 on both moves; no horizontal moves.
  - rd_ready low 5 cycles mid-FILL: rd_addr and rd_last stable; no duplicate or skipped address.
  - img_cols=2, K=3: cfg_err=1; done pulses one cycle after start; zero rd_valid.
  - ADDR_W=8, base_addr_r=254, 4x4: first reads 254, 255, 0; wrap is correct.
  - reset asserted during SHIFT: all outputs 0 in the same cycle; next start restarts at window (0,0).
